mem_xfer_unit: RTL and testbench

MEM_XFER_UNIT -- requirements
Module: mem_xfer_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wait_counter.sv | 31 +++
 rtl/mem_xfer_unit.sv | 127 ++++++++++++
 tb/tb_mem_xfer_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory transfer unit: FSM encoding and default widths.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/wait_counter.sv
// Counts memory wait cycles; expired flags that the counter has reached TIMEOUT.
module wait_counter
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A zero TIMEOUT still needs one bit of storage; expiry is then never flagged.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_xfer_unit.sv
// MAR/MDR front end with a single-outstanding memory read/write handshake,
// wait-cycle timeout and sticky error reporting.
module mem_xfer_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [DATA_W-1:0] BusMuxIn,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              start_rd,
  input  logic              start_wr,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  xfer_state_e       state_q, state_d;
  logic [ADDR_W-1:0] mar_d, addr_d;
  logic [DATA_W-1:0] mdr_d, wdata_d;
  logic              req_d, we_d, done_d, err_d, busy_d;
  logic              cnt_clr, cnt_en, cnt_expired;

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk     (Clock),
    .rst_n   (Clear),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  // Next state and next value of every registered output.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    done_d  = 1'b0;
    err_d   = err;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MARin) mar_d = BusMuxIn[ADDR_W-1:0];
        if (MDRin) mdr_d = BusMuxIn;
        if (start_rd && start_wr) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (start_rd || start_wr) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = start_wr;
          addr_d  = mar_q;
          wdata_d = mdr_q;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack wins over expiry when both land in the same cycle.
        if (mem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!mem_we) mdr_d = mem_rdata;
        end else if (cnt_expired) begin
          state_d = ST_ERR;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Directed self-checking bench for mem_xfer_unit (TIMEOUT=4 instance).
module tb_mem_xfer_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 4;

  logic              Clock = 1'b0;
  logic              Clear;
  logic [DATA_W-1:0] BusMuxIn;
  logic              MARin, MDRin, start_rd, start_wr;
  logic [ADDR_W-1:0] mar_q, mem_addr;
  logic [DATA_W-1:0] mdr_q, mem_wdata, mem_rdata;
  logic              busy, done, err, mem_req, mem_we, mem_ack;

  int checks = 0;
  int errors = 0;

  mem_xfer_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .BusMuxIn  (BusMuxIn),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .mar_q     (mar_q),
    .mdr_q     (mdr_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " mar_q"},     32'(mar_q),     32'h0);
    check({tag, " mdr_q"},     mdr_q,          32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " done"},      32'(done),      32'h0);
    check({tag, " err"},       32'(err),       32'h0);
    check({tag, " mem_req"},   32'(mem_req),   32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_wdata"}, mem_wdata,      32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clear = 1'b0; BusMuxIn = '0; MARin = 0; MDRin = 0;
    start_rd = 0; start_wr = 0; mem_ack = 0; mem_rdata = '0;
    #2;
    check_idle_zero("reset");

    // Release reset between edges, then load MAR=0x05.
    #10;
    Clear = 1'b1;
    MARin = 1; BusMuxIn = 32'h5;
    tick();
    MARin = 0;
    check("load mar", 32'(mar_q), 32'h5);

    // Zero-wait read.
    start_rd = 1;
    tick();
    start_rd = 0;
    check("rd req",  32'(mem_req),  32'h1);
    check("rd we",   32'(mem_we),   32'h0);
    check("rd addr", 32'(mem_addr), 32'h5);
    check("rd busy", 32'(busy),     32'h1);
    check("rd done early", 32'(done), 32'h0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    check("rd mdr",  mdr_q,         32'hDEADBEEF);
    check("rd done", 32'(done),     32'h1);
    check("rd req off", 32'(mem_req), 32'h0);
    check("rd err",  32'(err),      32'h0);
    tick();
    check("rd done pulse", 32'(done), 32'h0);
    check("rd idle busy",  32'(busy), 32'h0);

    // Write with 3 wait cycles.
    MARin = 1; BusMuxIn = 32'h1FF;
    tick();
    MARin = 0; MDRin = 1; BusMuxIn = 32'h12345678;
    tick();
    MDRin = 0;
    check("wr mar", 32'(mar_q), 32'h1FF);
    check("wr mdr", mdr_q,      32'h12345678);
    start_wr = 1;
    tick();
    start_wr = 0;
    for (int i = 0; i < 4; i++) begin
      check("wr req",   32'(mem_req),  32'h1);
      check("wr we",    32'(mem_we),   32'h1);
      check("wr addr",  32'(mem_addr), 32'h1FF);
      check("wr wdata", mem_wdata,     32'h12345678);
      check("wr no done", 32'(done),   32'h0);
      if (i == 3) mem_ack = 1;
      mem_rdata = 32'hFFFF0000;
      tick();
    end
    mem_ack = 0;
    check("wr done", 32'(done),     32'h1);
    check("wr req off", 32'(mem_req), 32'h0);
    check("wr mdr kept", mdr_q,     32'h12345678);
    tick();
    check("wr done pulse", 32'(done), 32'h0);

    // Timeout: no ack, counter runs 0..4 in REQ, then ERR.
    start_rd = 1;
    tick();
    start_rd = 0;
    mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      check("to req",  32'(mem_req), 32'h1);
      check("to done", 32'(done),    32'h0);
      tick();
    end
    check("to err",      32'(err),     32'h1);
    check("to done",     32'(done),    32'h1);
    check("to req off",  32'(mem_req), 32'h0);
    check("to mdr kept", mdr_q,        32'h12345678);
    tick();
    check("to done pulse", 32'(done), 32'h0);
    check("to err sticky", 32'(err),  32'h1);
    check("to idle busy",  32'(busy), 32'h0);
    tick();
    check("to err hold", 32'(err), 32'h1);

    // Next accepted start clears err.
    start_rd = 1;
    tick();
    start_rd = 0;
    check("clr err",     32'(err),     32'h0);
    check("clr err req", 32'(mem_req), 32'h1);
    mem_ack = 1; mem_rdata = 32'h0BADCAFE;
    tick();
    mem_ack = 0;
    check("clr err mdr", mdr_q, 32'h0BADCAFE);
    tick();

    // Simultaneous start_rd and start_wr.
    start_rd = 1; start_wr = 1;
    tick();
    start_rd = 0; start_wr = 0;
    check("both err",  32'(err),     32'h1);
    check("both done", 32'(done),    32'h1);
    check("both req",  32'(mem_req), 32'h0);
    check("both busy", 32'(busy),    32'h0);
    tick();
    check("both done pulse", 32'(done),    32'h0);
    check("both req later",  32'(mem_req), 32'h0);

    // Busy lockout: loads and starts during REQ are ignored.
    start_rd = 1;
    tick();
    start_rd = 0;
    MARin = 1; MDRin = 1; BusMuxIn = 32'h0AA; start_rd = 1; start_wr = 1;
    tick();
    MARin = 0; MDRin = 0; start_rd = 0; start_wr = 0;
    check("lock mar",  32'(mar_q),    32'h1FF);
    check("lock mdr",  mdr_q,         32'h0BADCAFE);
    check("lock addr", 32'(mem_addr), 32'h1FF);
    check("lock we",   32'(mem_we),   32'h0);
    check("lock req",  32'(mem_req),  32'h1);
    check("lock err",  32'(err),      32'h0);
    mem_ack = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_ack = 0;
    check("lock mdr rd", mdr_q,     32'h55AA55AA);
    check("lock done",   32'(done), 32'h1);
    tick();

    // Ack in IDLE is ignored.
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 0;
    check("idle ack mdr",  mdr_q,     32'h55AA55AA);
    check("idle ack busy", 32'(busy), 32'h0);
    check("idle ack done", 32'(done), 32'h0);

    // Reset in the middle of a write.
    start_wr = 1;
    tick();
    start_wr = 0;
    check("rst pre req", 32'(mem_req), 32'h1);
    #2;
    Clear = 1'b0;
    #1;
    check_idle_zero("rst async");
    tick();
    check("rst no done", 32'(done), 32'h0);
    @(negedge Clock);
    Clear = 1'b1; start_rd = 1;
    tick();
    start_rd = 0;
    check("post rst req",  32'(mem_req),  32'h1);
    check("post rst addr", 32'(mem_addr), 32'h0);
    check("post rst we",   32'(mem_we),   32'h0);
    mem_ack = 1; mem_rdata = 32'h600DF00D;
    tick();
    mem_ack = 0;
    check("post rst mdr",  mdr_q,     32'h600DF00D);
    check("post rst done", 32'(done), 32'h1);
    tick();
    check("post rst idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
